// File: rtl/au_addsub_mp_seq_pkg.sv
// Shared definitions for the multi-precision add/sub sequencer: FSM state
// encodings and the word-counter width helper.
package au_addsub_mp_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Word counter must address NWORD words; a single-word operand still needs one bit
  function automatic int cnt_w(input int nword);
    return (nword > 1) ? $clog2(nword) : 1;
  endfunction

endpackage

// File: rtl/au_addsub_mp_seq_cv.sv
// AU_addsub_cv: combinational WIDTH-bit add/sub slice with parallel-prefix carry
// logic (ARCH 0: Kogge-Stone, 1: Sklansky, 2: serial prefix chain).
module AU_addsub_cv #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_ci,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co,
  output logic             o_cmsb
);

  localparam int LV = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_gg;
  logic [WIDTH-1:0] w_pg;
  logic [WIDTH:0]   w_c;

  assign w_b = i_b ^ {WIDTH{i_sub}};
  assign w_p = i_a ^ w_b;
  assign w_g = i_a & w_b;

  // Group generate/propagate over bits [i:0]; networks are updated in place, so
  // Kogge-Stone walks downward and Sklansky partners never change within a level.
  always_comb begin
    w_gg = w_g;
    w_pg = w_p;
    if (ARCH == 2) begin
      for (int i = 1; i < WIDTH; i++) begin
        w_gg[i] = w_gg[i] | (w_pg[i] & w_gg[i-1]);
        w_pg[i] = w_pg[i] & w_pg[i-1];
      end
    end else begin
      for (int l = 0; l < LV; l++) begin
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (ARCH == 0) begin
            if (i >= (1 << l)) begin
              w_gg[i] = w_gg[i] | (w_pg[i] & w_gg[i-(1<<l)]);
              w_pg[i] = w_pg[i] & w_pg[i-(1<<l)];
            end
          end else begin
            if (((i >> l) & 1) == 1) begin
              w_gg[i] = w_gg[i] | (w_pg[i] & w_gg[((i >> l) << l) - 1]);
              w_pg[i] = w_pg[i] & w_pg[((i >> l) << l) - 1];
            end
          end
        end
      end
    end
  end

  assign w_c    = {w_gg | (w_pg & {WIDTH{i_ci}}), i_ci};
  assign o_s    = w_p ^ w_c[WIDTH-1:0];
  assign o_co   = w_c[WIDTH];
  assign o_cmsb = w_c[WIDTH-1];

endmodule

// File: rtl/au_addsub_mp_seq.sv
// Multi-precision a +/- b +/- ci sequencer: one WIDTH-bit slice reused LSW first.
// Optional zero flag output z enabled by AU_ADDSUB_MP_SEQ_ZFLAG_EN.
module au_addsub_mp_seq
  import au_addsub_mp_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NWORD = 4,
  parameter int ARCH  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*NWORD-1:0] a,
  input  logic [WIDTH*NWORD-1:0] b,
  input  logic                   ci,
  input  logic                   add_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*NWORD-1:0] s,
  output logic                   co,
`ifdef AU_ADDSUB_MP_SEQ_ZFLAG_EN
  output logic                   v,
  output logic                   z
`else
  output logic                   v
`endif
);

  localparam int TW = WIDTH * NWORD;
  localparam int CW = cnt_w(NWORD);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_sub;
  logic [TW-1:0]    r_a;
  logic [TW-1:0]    r_b;
  logic [TW-1:0]    r_s;
  logic             r_co;
  logic             r_v;

  logic [WIDTH-1:0] w_a_k;
  logic [WIDTH-1:0] w_b_k;
  logic [WIDTH-1:0] w_sum;
  logic             w_co;
  logic             w_cmsb;
  logic             w_last;

  assign w_a_k  = r_a[int'(r_cnt)*WIDTH +: WIDTH];
  assign w_b_k  = r_b[int'(r_cnt)*WIDTH +: WIDTH];
  assign w_last = (r_cnt == CW'(NWORD - 1));

  AU_addsub_cv #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_slice (
    .i_a    (w_a_k),
    .i_b    (w_b_k),
    .i_sub  (r_sub),
    .i_ci   (r_carry),
    .o_s    (w_sum),
    .o_co   (w_co),
    .o_cmsb (w_cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= add_sub;
            // Subtraction is a + ~b + 1, so the initial carry folds in the +1
            r_carry <= ci ^ add_sub;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_s[int'(r_cnt)*WIDTH +: WIDTH] <= w_sum;
          r_carry <= w_co;
          if (w_last) begin
            r_co    <= w_co;
            r_v     <= w_cmsb ^ w_co;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef AU_ADDSUB_MP_SEQ_ZFLAG_EN
  logic r_z;

  // Sticky AND of per-word zero; armed at acceptance, final once DONE is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z <= 1'b0;
    end else if (r_state == ST_IDLE && in_valid) begin
      r_z <= 1'b1;
    end else if (r_state == ST_RUN) begin
      r_z <= r_z & (w_sum == '0);
    end
  end

  assign z = r_z;
`endif

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign s         = r_s;
  assign co        = r_co;
  assign v         = r_v;

endmodule

// File: tb/tb_au_addsub_mp_seq.sv
// Self-checking bench for au_addsub_mp_seq (WIDTH=8, NWORD=4): vector table,
// random model-checked ops, backpressure and mid-run reset sequences.
module tb_au_addsub_mp_seq;

  localparam int W  = 8;
  localparam int NW = 4;
  localparam int TW = W * NW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          ci;
  logic          add_sub;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] s;
  logic          co;
  logic          v;
`ifdef AU_ADDSUB_MP_SEQ_ZFLAG_EN
  logic          z;
`endif

  typedef struct {
    logic [TW-1:0] s;
    logic          co;
    logic          v;
    logic          z;
  } exp_t;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          ci;
    logic          sub;
    logic [TW-1:0] s;
    logic          co;
    logic          v;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_cmp;
  int   n_fail;

  au_addsub_mp_seq #(
    .WIDTH (W),
    .NWORD (NW),
    .ARCH  (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .add_sub   (add_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
`ifdef AU_ADDSUB_MP_SEQ_ZFLAG_EN
    .v         (v),
    .z         (z)
`else
    .v         (v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [TW-1:0] ma, input logic [TW-1:0] mb,
                                 input logic mci, input logic msub);
    logic [TW:0]   full;
    logic [TW-1:0] bx;
    exp_t          e;
    bx   = mb ^ {TW{msub}};
    full = {1'b0, ma} + {1'b0, bx} + {{TW{1'b0}}, mci ^ msub};
    e.s  = full[TW-1:0];
    e.co = full[TW];
    e.v  = (ma[TW-1] == bx[TW-1]) && (e.s[TW-1] != ma[TW-1]);
    e.z  = (e.s == '0);
    return e;
  endfunction

  task automatic check_out(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_s"},  64'(s),  64'(e.s));
      chk({nm, "_co"}, 64'(co), 64'(e.co));
      chk({nm, "_v"},  64'(v),  64'(e.v));
`ifdef AU_ADDSUB_MP_SEQ_ZFLAG_EN
      chk({nm, "_z"},  64'(z),  64'(e.z));
`endif
    end
  endtask

  // Waits for in_ready, performs the acceptance edge, then scrambles the inputs
  task automatic accept(input logic [TW-1:0] ta, input logic [TW-1:0] tb,
                        input logic tci, input logic tsub, input string nm);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) chk({nm, "_ready_timeout"}, 64'd0, 64'd1);
    a = ta; b = tb; ci = tci; add_sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom} & {TW{1'b1}};
    b = {$urandom, $urandom} & {TW{1'b1}};
    ci = 1'($urandom);
    add_sub = 1'($urandom);
  endtask

  task automatic wait_result(input string nm);
    int lat;
    lat = 0;
    while (!out_valid && lat < NW + 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(NW));
  endtask

  task automatic run_op(input logic [TW-1:0] ta, input logic [TW-1:0] tb,
                        input logic tci, input logic tsub, input exp_t e, input string nm);
    accept(ta, tb, tci, tsub, nm);
    sb.push_back(e);
    wait_result(nm);
    check_out(nm);
    @(posedge clk); #1;
    chk({nm, "_idle_ovalid"}, 64'(out_valid), 64'd0);
    chk({nm, "_idle_iready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    exp_t        e;
    exp_t        snap;
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;
    logic        rci;
    logic        rsub;

    n_cmp = 0;
    n_fail = 0;
    tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[2] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[3] = '{32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
    tbl[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[6] = '{32'h00000010, 32'h00000003, 1'b1, 1'b1, 32'h0000000C, 1'b1, 1'b0};
    tbl[7] = '{32'h000000FF, 32'h00000000, 1'b1, 1'b0, 32'h00000100, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0; add_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_iready", 64'(in_ready), 64'd1);
    chk("reset_ovalid", 64'(out_valid), 64'd0);
    chk("reset_s", 64'(s), 64'd0);
    chk("reset_co", 64'(co), 64'd0);
    chk("reset_v", 64'(v), 64'd0);
`ifdef AU_ADDSUB_MP_SEQ_ZFLAG_EN
    chk("reset_z", 64'(z), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      e.s = tbl[i].s; e.co = tbl[i].co; e.v = tbl[i].v; e.z = (tbl[i].s == '0);
      run_op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub, e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom; rci = 1'($urandom); rsub = 1'($urandom);
      if (i == 3) rb = ra;
      run_op(ra, rb, rci, rsub, model(ra, rb, rci, rsub), $sformatf("rnd%0d", i));
    end

    // Backpressure: result held in DONE while new operands are offered
    out_ready = 1'b0;
    accept(32'h12345678, 32'h11111111, 1'b0, 1'b0, "bp");
    sb.push_back(model(32'h12345678, 32'h11111111, 1'b0, 1'b0));
    wait_result("bp");
    snap.s = s; snap.co = co; snap.v = v;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_s", k), 64'(s), 64'(snap.s));
      chk($sformatf("bp%0d_co", k), 64'(co), 64'(snap.co));
      chk($sformatf("bp%0d_ovalid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_iready", k), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check_out("bp");
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_ovalid", 64'(out_valid), 64'd0);
    chk("bp_rel_iready", 64'(in_ready), 64'd1);
    chk("bp_rel_s_hold", 64'(s), 64'(32'h23456789));
    run_op(32'h00000001, 32'h00000002, 1'b0, 1'b0, model(32'h1, 32'h2, 1'b0, 1'b0), "post_bp");

    // Reset asserted in the middle of RUN discards the partial result
    accept(32'hDEADBEEF, 32'h01010101, 1'b1, 1'b0, "rstrun");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstrun_iready", 64'(in_ready), 64'd1);
    chk("rstrun_ovalid", 64'(out_valid), 64'd0);
    chk("rstrun_s", 64'(s), 64'd0);
    chk("rstrun_co", 64'(co), 64'd0);
    chk("rstrun_v", 64'(v), 64'd0);
    #2;
    rst = 1'b0;
    repeat (NW + 2) @(posedge clk);
    #1;
    chk("rstrun_stay_idle", 64'(out_valid), 64'd0);
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, model(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0), "post_rst");
    run_op(32'h00000005, 32'h00000003, 1'b0, 1'b1, model(32'h5, 32'h3, 1'b0, 1'b1), "post_rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
